level_select_ctrl: RTL and testbench

LEVEL_SELECT_CTRL -- requirements
Module: level_select_ctrl

---
 rtl/game_pkg.sv | 54 +++++
 rtl/game_set_if.sv | 33 +++
 rtl/seq_mult_add.sv | 61 ++++++
 rtl/level_select_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_level_select_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared game definitions: field widths, FSM state encoding,
//                fixed difficulty table and its lookup helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Field widths shared by the level controller and the game-set interface
    localparam int c_NUM_W   = 5;
    localparam int c_SIZE_W  = 7;
    localparam int c_BOARD_W = 11;
    localparam int c_TBL_MINES_W = 8;

    // Smallest legal custom values
    localparam logic [c_NUM_W-1:0]  c_MIN_NUM  = 5'd2;
    localparam logic [c_SIZE_W-1:0] c_MIN_SIZE = 7'd8;

    // Level controller states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_MULT   = 3'd2,
        ST_PLACE  = 3'd3,
        ST_ACTIVE = 3'd4
    } state_e;

    // One row of the difficulty table
    typedef struct packed {
        logic [c_NUM_W-1:0]       num;
        logic [c_SIZE_W-1:0]      size;
        logic [c_TBL_MINES_W-1:0] mines;
    } level_cfg_t;

    localparam level_cfg_t c_LVL1 = '{num: 5'd8,  size: 7'd50, mines: 8'd8};
    localparam level_cfg_t c_LVL2 = '{num: 5'd10, size: 7'd50, mines: 8'd20};
    localparam level_cfg_t c_LVL3 = '{num: 5'd16, size: 7'd40, mines: 8'd60};

    // Fixed levels 1..3; index 3 sits in the most significant slot
    localparam level_cfg_t [3:1] LEVEL_TABLE = {c_LVL3, c_LVL2, c_LVL1};

    // Returns the table row for a fixed level, all-zero for anything else
    function automatic level_cfg_t table_lookup(input logic [31:0] idx);
        case (idx)
            32'd1:   return LEVEL_TABLE[1];
            32'd2:   return LEVEL_TABLE[2];
            32'd3:   return LEVEL_TABLE[3];
            default: return '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_set_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_set_if
//  Description : Board geometry bundle handed from the level controller to
//                the renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface game_set_if;

    logic [game_pkg::c_NUM_W-1:0]   button_num;
    logic [game_pkg::c_BOARD_W-1:0] board_size;
    logic [game_pkg::c_BOARD_W-1:0] board_xpos;
    logic [game_pkg::c_BOARD_W-1:0] board_ypos;
    logic [game_pkg::c_SIZE_W-1:0]  button_size;

    modport out (
        output button_num,
        output board_size,
        output board_xpos,
        output board_ypos,
        output button_size
    );

    modport in (
        input button_num,
        input board_size,
        input board_xpos,
        input board_ypos,
        input button_size
    );

endinterface
`default_nettype wire

// File: rtl/seq_mult_add.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_add
//  Description : Iterative multiplier, product = a * b by adding b once per
//                cycle for a cycles. start always reloads, so a new job
//                overrides one still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_add #(
    parameter int A_W = 5,
    parameter int B_W = 7,
    parameter int P_W = 11
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic           busy,
    output logic           done,
    output logic [P_W-1:0] product
);

    logic [A_W-1:0] r_cnt;
    logic [B_W-1:0] r_b;
    logic [P_W-1:0] r_acc;
    logic           r_busy;
    logic           r_done;

    // Load operands on start, then one accumulate per cycle until the count expires
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_cnt  <= a;
            r_b    <= b;
            r_acc  <= '0;
            r_busy <= (a != '0);
            r_done <= (a == '0);
        end else if (r_busy) begin
            r_acc <= r_acc + P_W'(r_b);
            r_cnt <= r_cnt - A_W'(1);
            if (r_cnt == A_W'(1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_acc;

endmodule
`default_nettype wire

// File: rtl/level_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : level_select_ctrl
//  Description : Accepts a difficulty request, resolves button count/size and
//                mine count (table or clamped custom values), sizes the board
//                with an iterative multiplier, centres it and holds the
//                resulting configuration until restart.
//  Revision    : 1.0 - initial release
// ============================================================================
module level_select_ctrl
    import game_pkg::*;
#(
    parameter int NUM_LEVELS  = 4,
    parameter int MINES_W     = 8,
    parameter int X_CENTER    = 720,
    parameter int Y_CENTER    = 450,
    parameter int MAX_BUTTONS = 16,
    parameter int BOARD_MAX   = 800
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(NUM_LEVELS+1)-1:0] level,
    input  logic                          level_req,
    output logic                          req_ready,
    input  logic [4:0]                    custom_num,
    input  logic [6:0]                    custom_size,
    input  logic [MINES_W-1:0]            custom_mines,
    input  logic                          restart,
    output logic [MINES_W-1:0]            mines_out,
    output logic                          cfg_valid,
    output logic                          level_enable,
    output logic                          level_err,
    game_set_if.out                       out
);

    localparam int c_LVL_W = $clog2(NUM_LEVELS+1);

    state_e                 r_state;
    logic                   r_ready;
    logic [c_LVL_W-1:0]     r_level;
    logic [c_NUM_W-1:0]     r_num;
    logic [c_SIZE_W-1:0]    r_size;
    logic [MINES_W-1:0]     r_mines;
    logic [c_BOARD_W-1:0]   r_board;

    logic [c_NUM_W-1:0]     r_out_num;
    logic [c_SIZE_W-1:0]    r_out_size;
    logic [c_BOARD_W-1:0]   r_out_board;
    logic [c_BOARD_W-1:0]   r_out_xpos;
    logic [c_BOARD_W-1:0]   r_out_ypos;
    logic [MINES_W-1:0]     r_out_mines;
    logic                   r_cfg_valid;
    logic                   r_enable;
    logic                   r_err;

    level_cfg_t             w_tbl;
    logic [c_NUM_W-1:0]     w_num;
    logic [c_SIZE_W-1:0]    w_size;
    logic [MINES_W-1:0]     w_mines;
    logic [31:0]            w_mines_max;
    logic                   w_level_ok;
    logic [c_BOARD_W-1:0]   w_half;
    logic [c_BOARD_W-1:0]   w_xpos;
    logic [c_BOARD_W-1:0]   w_ypos;
    logic                   w_start;
    logic                   w_busy;
    logic                   w_done;
    logic [c_BOARD_W-1:0]   w_product;

    assign w_level_ok = (level != '0) && (32'(level) <= NUM_LEVELS);

    // Resolve the requested level into clamped num/size/mines
    always_comb begin
        w_tbl       = table_lookup(32'(r_level));
        w_num       = w_tbl.num;
        w_size      = w_tbl.size;
        w_mines     = MINES_W'(w_tbl.mines);
        w_mines_max = '0;
        if (32'(r_level) == NUM_LEVELS) begin
            if (custom_num < c_MIN_NUM)
                w_num = c_MIN_NUM;
            else if (32'(custom_num) > MAX_BUTTONS)
                w_num = c_NUM_W'(MAX_BUTTONS);
            else
                w_num = custom_num;
            w_size      = (custom_size < c_MIN_SIZE) ? c_MIN_SIZE : custom_size;
            w_mines_max = 32'(w_num) * 32'(w_num) - 32'd1;
            if (custom_mines == '0)
                w_mines = MINES_W'(1);
            else if (32'(custom_mines) > w_mines_max)
                w_mines = MINES_W'(w_mines_max);
            else
                w_mines = custom_mines;
        end
    end

    // Centre the board; a half-size wider than the centre pins the edge at 0
    always_comb begin
        w_half = r_board >> 1;
        w_xpos = (32'(w_half) > X_CENTER) ? '0 : c_BOARD_W'(32'(X_CENTER) - 32'(w_half));
        w_ypos = (32'(w_half) > Y_CENTER) ? '0 : c_BOARD_W'(32'(Y_CENTER) - 32'(w_half));
    end

    // The multiplier is launched from the same resolved values LOOKUP latches
    assign w_start = (r_state == ST_LOOKUP) && !restart;

    seq_mult_add #(
        .A_W (c_NUM_W),
        .B_W (c_SIZE_W),
        .P_W (c_BOARD_W)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start),
        .a       (w_num),
        .b       (w_size),
        .busy    (w_busy),
        .done    (w_done),
        .product (w_product)
    );

    // Request/compute/hold sequencing with registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_level     <= '0;
            r_num       <= '0;
            r_size      <= '0;
            r_mines     <= '0;
            r_board     <= '0;
            r_out_num   <= '0;
            r_out_size  <= '0;
            r_out_board <= '0;
            r_out_xpos  <= '0;
            r_out_ypos  <= '0;
            r_out_mines <= '0;
            r_cfg_valid <= 1'b0;
            r_enable    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_enable <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    // restart is meaningless here, so a coincident request proceeds
                    if (level_req && r_ready) begin
                        if (w_level_ok) begin
                            r_level <= level;
                            r_state <= ST_LOOKUP;
                            r_ready <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_LOOKUP: begin
                    if (restart) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_num   <= w_num;
                        r_size  <= w_size;
                        r_mines <= w_mines;
                        r_state <= ST_MULT;
                    end
                end
                ST_MULT: begin
                    if (restart) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end else if (w_done && !w_busy) begin
                        r_board <= w_product;
                        r_state <= ST_PLACE;
                    end
                end
                ST_PLACE: begin
                    if (restart) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end else if (32'(r_board) > BOARD_MAX) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_out_num   <= r_num;
                        r_out_size  <= r_size;
                        r_out_board <= r_board;
                        r_out_xpos  <= w_xpos;
                        r_out_ypos  <= w_ypos;
                        r_out_mines <= r_mines;
                        r_cfg_valid <= 1'b1;
                        r_enable    <= 1'b1;
                        r_state     <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (restart) begin
                        r_out_num   <= '0;
                        r_out_size  <= '0;
                        r_out_board <= '0;
                        r_out_xpos  <= '0;
                        r_out_ypos  <= '0;
                        r_out_mines <= '0;
                        r_cfg_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                        r_ready     <= 1'b1;
                    end
                end
                default: begin
                    r_out_num   <= '0;
                    r_out_size  <= '0;
                    r_out_board <= '0;
                    r_out_xpos  <= '0;
                    r_out_ypos  <= '0;
                    r_out_mines <= '0;
                    r_cfg_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                    r_ready     <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready       = r_ready;
    assign mines_out       = r_out_mines;
    assign cfg_valid       = r_cfg_valid;
    assign level_enable    = r_enable;
    assign level_err       = r_err;
    assign out.button_num  = r_out_num;
    assign out.button_size = r_out_size;
    assign out.board_size  = r_out_board;
    assign out.board_xpos  = r_out_xpos;
    assign out.board_ypos  = r_out_ypos;

endmodule
`default_nettype wire

// File: tb/tb_level_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_level_select_ctrl
//  Description : Directed self-checking bench for level_select_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_level_select_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] level;
    logic       level_req;
    logic       req_ready;
    logic [4:0] custom_num;
    logic [6:0] custom_size;
    logic [7:0] custom_mines;
    logic       restart;
    logic [7:0] mines_out;
    logic       cfg_valid;
    logic       level_enable;
    logic       level_err;

    int checks;
    int failures;

    game_set_if u_if ();

    level_select_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .level        (level),
        .level_req    (level_req),
        .req_ready    (req_ready),
        .custom_num   (custom_num),
        .custom_size  (custom_size),
        .custom_mines (custom_mines),
        .restart      (restart),
        .mines_out    (mines_out),
        .cfg_valid    (cfg_valid),
        .level_enable (level_enable),
        .level_err    (level_err),
        .out          (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a request for one clock; returns at the negedge after the accepting edge
    task automatic send_req(input logic [2:0] lvl);
        @(negedge clk);
        level     = lvl;
        level_req = 1'b1;
        @(negedge clk);
        level_req = 1'b0;
    endtask

    // Count cycles after the accepting edge until cfg_valid (or level_err) appears
    task automatic wait_result(output int cyc, output bit early_en, output bit got_err);
        cyc      = 0;
        early_en = 1'b0;
        got_err  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (level_err) begin
                got_err = 1'b1;
                break;
            end
            if (cfg_valid) break;
            if (level_enable) early_en = 1'b1;
        end
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0d exp=0", req_ready); end
        checks++; if (cfg_valid !== 1'b0) begin failures++; $display("FAIL rst_cfg_valid got=%0d exp=0", cfg_valid); end
        checks++; if ({level_enable, level_err} !== 2'b00) begin failures++; $display("FAIL rst_pulses got=%b exp=00", {level_enable, level_err}); end
        checks++; if (u_if.board_size !== 11'd0 || mines_out !== 8'd0) begin failures++; $display("FAIL rst_outputs got=%0d/%0d exp=0/0", u_if.board_size, mines_out); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%0d exp=1", req_ready); end
    endtask

    task automatic test_level1();
        int cyc; bit early; bit err;
        send_req(3'd1);
        wait_result(cyc, early, err);
        checks++; if (cyc !== 11) begin failures++; $display("FAIL l1_latency got=%0d exp=11", cyc); end
        checks++; if (early !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL l1_early_pulse got=%0d/%0d exp=0/0", early, err); end
        checks++; if (level_enable !== 1'b1) begin failures++; $display("FAIL l1_enable got=%0d exp=1", level_enable); end
        checks++; if (u_if.button_num !== 5'd8 || u_if.button_size !== 7'd50) begin failures++; $display("FAIL l1_button got=%0d/%0d exp=8/50", u_if.button_num, u_if.button_size); end
        checks++; if (u_if.board_size !== 11'd400) begin failures++; $display("FAIL l1_board got=%0d exp=400", u_if.board_size); end
        checks++; if (u_if.board_xpos !== 11'd520 || u_if.board_ypos !== 11'd250) begin failures++; $display("FAIL l1_pos got=%0d/%0d exp=520/250", u_if.board_xpos, u_if.board_ypos); end
        checks++; if (mines_out !== 8'd8) begin failures++; $display("FAIL l1_mines got=%0d exp=8", mines_out); end
        repeat (3) @(negedge clk);
        checks++; if (level_enable !== 1'b0) begin failures++; $display("FAIL l1_enable_pulse got=%0d exp=0", level_enable); end
        checks++; if (cfg_valid !== 1'b1 || u_if.board_size !== 11'd400 || req_ready !== 1'b0) begin failures++; $display("FAIL l1_hold got=%0d/%0d/%0d exp=1/400/0", cfg_valid, u_if.board_size, req_ready); end
        do_restart();
        checks++; if (cfg_valid !== 1'b0 || u_if.board_size !== 11'd0 || mines_out !== 8'd0 || u_if.board_xpos !== 11'd0) begin failures++; $display("FAIL l1_restart got=%0d/%0d/%0d exp=0/0/0", cfg_valid, u_if.board_size, mines_out); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL l1_restart_ready got=%0d exp=1", req_ready); end
    endtask

    task automatic test_level3();
        int cyc; bit early; bit err;
        send_req(3'd3);
        wait_result(cyc, early, err);
        checks++; if (cyc !== 19) begin failures++; $display("FAIL l3_latency got=%0d exp=19", cyc); end
        checks++; if (u_if.board_size !== 11'd640) begin failures++; $display("FAIL l3_board got=%0d exp=640", u_if.board_size); end
        checks++; if (u_if.board_xpos !== 11'd400 || u_if.board_ypos !== 11'd130) begin failures++; $display("FAIL l3_pos got=%0d/%0d exp=400/130", u_if.board_xpos, u_if.board_ypos); end
        checks++; if (mines_out !== 8'd60 || u_if.button_num !== 5'd16) begin failures++; $display("FAIL l3_mines_num got=%0d/%0d exp=60/16", mines_out, u_if.button_num); end
        do_restart();
    endtask

    task automatic test_invalid();
        logic [2:0] bad [2];
        bad[0] = 3'd0;
        bad[1] = 3'd5;
        for (int i = 0; i < 2; i++) begin
            send_req(bad[i]);
            checks++; if (level_err !== 1'b1) begin failures++; $display("FAIL inv_err lvl=%0d got=%0d exp=1", bad[i], level_err); end
            checks++; if (req_ready !== 1'b1 || cfg_valid !== 1'b0) begin failures++; $display("FAIL inv_idle lvl=%0d got=%0d/%0d exp=1/0", bad[i], req_ready, cfg_valid); end
            @(negedge clk);
            checks++; if (level_err !== 1'b0) begin failures++; $display("FAIL inv_err_pulse lvl=%0d got=%0d exp=0", bad[i], level_err); end
            repeat (12) @(negedge clk);
            checks++; if (cfg_valid !== 1'b0) begin failures++; $display("FAIL inv_no_cfg lvl=%0d got=%0d exp=0", bad[i], cfg_valid); end
        end
    endtask

    task automatic test_custom();
        int cyc; bit early; bit err;
        custom_num = 5'd20; custom_size = 7'd40; custom_mines = 8'd255;
        send_req(3'd4);
        wait_result(cyc, early, err);
        checks++; if (cyc !== 19) begin failures++; $display("FAIL cust_latency got=%0d exp=19", cyc); end
        checks++; if (u_if.button_num !== 5'd16 || u_if.board_size !== 11'd640) begin failures++; $display("FAIL cust_clamp got=%0d/%0d exp=16/640", u_if.button_num, u_if.board_size); end
        checks++; if (mines_out !== 8'd255) begin failures++; $display("FAIL cust_mines got=%0d exp=255", mines_out); end
        do_restart();
        // low-side clamps: num 1->2, size 3->8, mines 0->1
        custom_num = 5'd1; custom_size = 7'd3; custom_mines = 8'd0;
        send_req(3'd4);
        wait_result(cyc, early, err);
        checks++; if (cyc !== 5) begin failures++; $display("FAIL cust_lo_latency got=%0d exp=5", cyc); end
        checks++; if (u_if.button_num !== 5'd2 || u_if.button_size !== 7'd8 || u_if.board_size !== 11'd16) begin failures++; $display("FAIL cust_lo_clamp got=%0d/%0d/%0d exp=2/8/16", u_if.button_num, u_if.button_size, u_if.board_size); end
        checks++; if (mines_out !== 8'd1 || u_if.board_xpos !== 11'd712 || u_if.board_ypos !== 11'd442) begin failures++; $display("FAIL cust_lo_misc got=%0d/%0d/%0d exp=1/712/442", mines_out, u_if.board_xpos, u_if.board_ypos); end
        do_restart();
        // mines above num*num-1: 5x5 board caps at 24
        custom_num = 5'd5; custom_size = 7'd20; custom_mines = 8'd100;
        send_req(3'd4);
        wait_result(cyc, early, err);
        checks++; if (mines_out !== 8'd24 || u_if.board_size !== 11'd100) begin failures++; $display("FAIL cust_mine_cap got=%0d/%0d exp=24/100", mines_out, u_if.board_size); end
        do_restart();
    endtask

    task automatic test_too_big();
        int cyc; bit early; bit err;
        custom_num = 5'd16; custom_size = 7'd60; custom_mines = 8'd10;
        send_req(3'd4);
        wait_result(cyc, early, err);
        checks++; if (err !== 1'b1 || cyc !== 19) begin failures++; $display("FAIL big_err got=%0d@%0d exp=1@19", err, cyc); end
        checks++; if (cfg_valid !== 1'b0 || early !== 1'b0 || u_if.board_size !== 11'd0) begin failures++; $display("FAIL big_outputs got=%0d/%0d/%0d exp=0/0/0", cfg_valid, early, u_if.board_size); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || level_err !== 1'b0) begin failures++; $display("FAIL big_idle got=%0d/%0d exp=1/0", req_ready, level_err); end
    endtask

    task automatic test_restart_mult();
        bit seen;
        send_req(3'd1);          // now in LOOKUP
        @(negedge clk);          // MULT
        @(negedge clk);          // MULT, first add done
        restart   = 1'b1;
        level     = 3'd2;
        level_req = 1'b1;
        @(negedge clk);
        restart   = 1'b0;
        level_req = 1'b0;
        checks++; if (req_ready !== 1'b1 || cfg_valid !== 1'b0 || level_enable !== 1'b0) begin failures++; $display("FAIL abort_idle got=%0d/%0d/%0d exp=1/0/0", req_ready, cfg_valid, level_enable); end
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (cfg_valid || level_enable) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_cfg got=%0d exp=0", seen); end
    endtask

    task automatic test_back_to_back();
        int cyc; bit early; bit err;
        // request coincident with restart in IDLE behaves normally
        @(negedge clk);
        restart = 1'b1;
        send_req(3'd2);
        restart = 1'b0;
        wait_result(cyc, early, err);
        checks++; if (cyc !== 13 || u_if.board_size !== 11'd500) begin failures++; $display("FAIL b2b_l2 got=%0d@%0d exp=500@13", u_if.board_size, cyc); end
        checks++; if (u_if.board_xpos !== 11'd470 || u_if.board_ypos !== 11'd200 || mines_out !== 8'd20) begin failures++; $display("FAIL b2b_l2_pos got=%0d/%0d/%0d exp=470/200/20", u_if.board_xpos, u_if.board_ypos, mines_out); end
    endtask

    task automatic test_reset_active();
        @(negedge clk);
        checks++; if (cfg_valid !== 1'b1) begin failures++; $display("FAIL rsta_pre got=%0d exp=1", cfg_valid); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++; if (cfg_valid !== 1'b0 || u_if.board_size !== 11'd0 || mines_out !== 8'd0 || level_enable !== 1'b0) begin failures++; $display("FAIL rsta_clear got=%0d/%0d/%0d exp=0/0/0", cfg_valid, u_if.board_size, mines_out); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rsta_ready_low got=%0d exp=0", req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || cfg_valid !== 1'b0) begin failures++; $display("FAIL rsta_release got=%0d/%0d exp=1/0", req_ready, cfg_valid); end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b0;
        level        = '0;
        level_req    = 1'b0;
        custom_num   = '0;
        custom_size  = '0;
        custom_mines = '0;
        restart      = 1'b0;
        test_reset();
        test_level1();
        test_level3();
        test_invalid();
        test_custom();
        test_too_big();
        test_restart_mult();
        test_back_to_back();
        test_reset_active();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
